voice_mixer: RTL and testbench

VOICE_MIXER -- requirements
Module: voice_mixer

---
 rtl/voice_mixer.sv | 135 +++++++++++++
 tb/tb_voice_mixer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_mixer.sv
// voice_mixer: multi-voice gain-ramped sample mixer producing one saturated PWM sample per frame
//   clk_in             - the only clock
//   rst_in             - asynchronous active-low reset
//   voice_on_in        - per-voice active flags, snapshotted at each frame tick
//   sample_in          - per-voice offset-binary samples, voice i at [i*SAMPLE_W +: SAMPLE_W]
//   vel_load_in        - one-cycle strobe writing vel_in into target[vel_index_in]
//   vel_index_in       - voice addressed by vel_load_in (out-of-range indices ignored)
//   vel_in             - target gain 0..255
//   clip_clr_in        - clears clip_out (a simultaneous clip event wins)
//   pwm_data_out       - mixed offset-binary sample, held between updates
//   pwm_data_ready_out - one-cycle pulse when pwm_data_out updates
//   busy_out           - high while a frame is being accumulated, scaled or output
//   clip_out           - sticky saturation flag
//   state_out          - FSM state (IDLE=0, ACCUM=1, SCALE=2, OUTPUT=3)
module voice_mixer #(
    parameter int NUM_VOICES    = 8,
    parameter int SAMPLE_W      = 8,
    parameter int SAMPLE_PERIOD = 4536,
    parameter int ATTEN_SHIFT   = 2,
    parameter int RAMP_STEP     = 4
) (
    input  logic                                            clk_in,
    input  logic                                            rst_in,
    input  logic [NUM_VOICES-1:0]                           voice_on_in,
    input  logic [NUM_VOICES*SAMPLE_W-1:0]                  sample_in,
    input  logic                                            vel_load_in,
    input  logic [(NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1)-1:0] vel_index_in,
    input  logic [7:0]                                      vel_in,
    input  logic                                            clip_clr_in,
    output logic [SAMPLE_W-1:0]                             pwm_data_out,
    output logic                                            pwm_data_ready_out,
    output logic                                            busy_out,
    output logic                                            clip_out,
    output logic [1:0]                                      state_out
);
    localparam int IDX_W  = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W  = SAMPLE_W + 9 + $clog2(NUM_VOICES);
    localparam int CNT_W  = $clog2(SAMPLE_PERIOD);
    localparam int STEP_C = RAMP_STEP > 255 ? 255 : RAMP_STEP;
    localparam logic [7:0] STEP = STEP_C[7:0];
    localparam logic [IDX_W:0] NV = (IDX_W + 1)'(NUM_VOICES);
    localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(2 ** (SAMPLE_W - 1));
    localparam logic signed [ACC_W-1:0] MID_S = ACC_W'(2 ** (SAMPLE_W - 1));
    localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(2 ** SAMPLE_W - 1);
    localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, SCALE = 2'd2, OUTPUT = 2'd3;

    logic [1:0]                  state;
    logic [CNT_W-1:0]            cnt;
    logic                        tick;
    logic [NUM_VOICES-1:0]       snap;
    logic [IDX_W-1:0]            idx;
    logic signed [ACC_W-1:0]     acc;
    logic [SAMPLE_W-1:0]         mix_q;
    logic [7:0]                  gain [NUM_VOICES];
    logic [7:0]                  target [NUM_VOICES];
    logic [7:0]                  g_cur, t_cur, g_use, g_next, diff;
    logic [SAMPLE_W-1:0]         smp;
    logic signed [SAMPLE_W-1:0]  centered;
    logic signed [SAMPLE_W+8:0]  prod;
    logic signed [ACC_W-1:0]     mix;
    logic                        sat_lo, sat_hi;
    logic [SAMPLE_W-1:0]         mix_sat;

    assign tick      = cnt == CNT_W'(SAMPLE_PERIOD - 1);
    assign busy_out  = state != IDLE;
    assign state_out = state;

    assign g_cur = gain[idx];
    assign t_cur = target[idx];
    // With no ramp the gain tracks the target outright, so the target is used directly
    assign g_use  = RAMP_STEP == 0 ? t_cur : g_cur;
    assign diff   = t_cur > g_cur ? t_cur - g_cur : g_cur - t_cur;
    assign g_next = (RAMP_STEP == 0 || diff <= STEP) ? t_cur : t_cur > g_cur ? g_cur + STEP : g_cur - STEP;
    // Flipping the MSB of an offset-binary sample yields its two's-complement centred value
    assign smp      = sample_in[idx*SAMPLE_W +: SAMPLE_W];
    assign centered = smp ^ MID;
    assign prod     = $signed({1'b0, g_use}) * centered;

    assign mix     = (acc >>> (7 + ATTEN_SHIFT)) + MID_S;
    assign sat_lo  = mix < 0;
    assign sat_hi  = mix > MAX_S;
    assign mix_sat = sat_lo ? '0 : sat_hi ? '1 : mix[SAMPLE_W-1:0];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state              <= IDLE;
            cnt                <= '0;
            snap               <= '0;
            idx                <= '0;
            acc                <= '0;
            mix_q              <= MID;
            pwm_data_out       <= MID;
            pwm_data_ready_out <= 1'b0;
            clip_out           <= 1'b0;
        end else begin
            cnt                <= tick ? '0 : cnt + 1'b1;
            pwm_data_ready_out <= state == OUTPUT;
            clip_out           <= (state == SCALE && (sat_lo || sat_hi)) ? 1'b1 : clip_clr_in ? 1'b0 : clip_out;
            case (state)
                IDLE: if (tick) begin
                    snap  <= voice_on_in;
                    acc   <= '0;
                    idx   <= '0;
                    state <= ACCUM;
                end
                ACCUM: begin
                    acc   <= snap[idx] ? acc + ACC_W'(prod) : acc;
                    idx   <= idx + 1'b1;
                    state <= idx == IDX_W'(NUM_VOICES - 1) ? SCALE : ACCUM;
                end
                SCALE: begin
                    mix_q <= mix_sat;
                    state <= OUTPUT;
                end
                default: begin
                    pwm_data_out <= mix_q;
                    state        <= IDLE;
                end
            endcase
        end
    end

    // A target written during a voice's own ACCUM step lands after this edge, so the ramp sees the old one
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                gain[i]   <= 8'd0;
                target[i] <= 8'd0;
            end
        end else begin
            if (vel_load_in && {1'b0, vel_index_in} < NV) target[vel_index_in] <= vel_in;
            if (state == ACCUM) gain[idx] <= snap[idx] ? g_next : 8'd0;
        end
    end
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: directed self-checking bench for voice_mixer
module tb_voice_mixer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] von;
    logic [7:0] smp [8];
    logic [63:0] sbus;
    logic       vl;
    logic [2:0] vi;
    logic [7:0] vv;
    logic       cc;
    logic [7:0] a_pwm, b_pwm, c_pwm;
    logic       a_rdy, b_rdy, c_rdy, a_busy, b_busy, c_busy, a_clip, b_clip, c_clip;
    logic [1:0] a_state, b_state, c_state;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    always_comb for (int i = 0; i < 8; i++) sbus[i*8 +: 8] = smp[i];

    voice_mixer dut_a (
        .clk_in(clk), .rst_in(rst_n), .voice_on_in(von), .sample_in(sbus),
        .vel_load_in(vl), .vel_index_in(vi), .vel_in(vv), .clip_clr_in(cc),
        .pwm_data_out(a_pwm), .pwm_data_ready_out(a_rdy), .busy_out(a_busy),
        .clip_out(a_clip), .state_out(a_state)
    );

    voice_mixer #(.SAMPLE_PERIOD(16), .RAMP_STEP(0)) dut_b (
        .clk_in(clk), .rst_in(rst_n), .voice_on_in(von), .sample_in(sbus),
        .vel_load_in(vl), .vel_index_in(vi), .vel_in(vv), .clip_clr_in(cc),
        .pwm_data_out(b_pwm), .pwm_data_ready_out(b_rdy), .busy_out(b_busy),
        .clip_out(b_clip), .state_out(b_state)
    );

    voice_mixer #(.SAMPLE_PERIOD(16), .RAMP_STEP(4), .ATTEN_SHIFT(0)) dut_c (
        .clk_in(clk), .rst_in(rst_n), .voice_on_in(von), .sample_in(sbus),
        .vel_load_in(vl), .vel_index_in(vi), .vel_in(vv), .clip_clr_in(cc),
        .pwm_data_out(c_pwm), .pwm_data_ready_out(c_rdy), .busy_out(c_busy),
        .clip_out(c_clip), .state_out(c_state)
    );

    task automatic apply_reset();
        rst_n = 1'b0;
        von = '0;
        vl = 1'b0;
        vi = '0;
        vv = '0;
        cc = 1'b0;
        for (int i = 0; i < 8; i++) smp[i] = 8'd128;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_target(input logic [2:0] i, input logic [7:0] v);
        vl = 1'b1;
        vi = i;
        vv = v;
        @(negedge clk);
        vl = 1'b0;
    endtask

    task automatic wait_ready(input int which, input int limit, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < limit) begin
            @(negedge clk);
            cyc++;
            got = which == 0 ? a_rdy : which == 1 ? b_rdy : c_rdy;
        end
    endtask

    task automatic wait_state_b(input logic [1:0] s, output bit got);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = b_state == s;
        end
    endtask

    task automatic test_reset();
        von = '0; vl = 1'b0; vi = '0; vv = '0; cc = 1'b0;
        for (int i = 0; i < 8; i++) smp[i] = 8'd128;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (a_pwm !== 8'd128) $display("FAIL reset_pwm_a got=%0d exp=128", a_pwm); else n_pass++;
        n_total++; if (b_pwm !== 8'd128) $display("FAIL reset_pwm_b got=%0d exp=128", b_pwm); else n_pass++;
        n_total++; if ({a_rdy, a_busy, a_clip} !== 3'b000) $display("FAIL reset_flags_a got=%b exp=000", {a_rdy, a_busy, a_clip}); else n_pass++;
        n_total++; if (a_state !== 2'd0 || b_state !== 2'd0) $display("FAIL reset_state got=%0d/%0d exp=0/0", a_state, b_state); else n_pass++;
    endtask

    task automatic test_frame_timing();
        int pulses = 0;
        bit got;
        int cyc;
        apply_reset();
        for (int e = 1; e <= 27; e++) begin
            @(negedge clk);
            pulses += int'(b_rdy);
            if (e == 15) begin
                n_total++; if (b_busy !== 1'b0 || b_state !== 2'd0) $display("FAIL tick_cycle_idle busy=%b state=%0d exp=0/0", b_busy, b_state); else n_pass++;
            end
            if (e == 16) begin
                n_total++; if (b_busy !== 1'b1 || b_state !== 2'd1) $display("FAIL accum_entry busy=%b state=%0d exp=1/1", b_busy, b_state); else n_pass++;
            end
            if (e == 24) begin
                n_total++; if (b_state !== 2'd2 || b_busy !== 1'b1) $display("FAIL scale_state state=%0d busy=%b exp=2/1", b_state, b_busy); else n_pass++;
            end
            if (e == 25) begin
                n_total++; if (b_state !== 2'd3 || b_rdy !== 1'b0) $display("FAIL output_state state=%0d rdy=%b exp=3/0", b_state, b_rdy); else n_pass++;
            end
            if (e == 26) begin
                n_total++; if (b_rdy !== 1'b1 || b_state !== 2'd0 || b_busy !== 1'b0) $display("FAIL ready_latency rdy=%b state=%0d busy=%b exp=1/0/0", b_rdy, b_state, b_busy); else n_pass++;
                n_total++; if (b_pwm !== 8'd128) $display("FAIL silent_mix got=%0d exp=128", b_pwm); else n_pass++;
            end
        end
        n_total++; if (pulses != 1) $display("FAIL ready_width pulses=%0d exp=1", pulses); else n_pass++;
        wait_ready(1, 40, got, cyc);
        n_total++; if (!got || cyc != 15) $display("FAIL frame_period got=%b cyc=%0d exp=15", got, cyc); else n_pass++;
    endtask

    task automatic test_default_idle();
        bit got;
        int cyc;
        apply_reset();
        wait_ready(0, 5000, got, cyc);
        n_total++; if (!got || cyc != 4546) $display("FAIL default_first_pulse got=%b cyc=%0d exp=4546", got, cyc); else n_pass++;
        n_total++; if (a_pwm !== 8'd128) $display("FAIL default_mix got=%0d exp=128", a_pwm); else n_pass++;
        wait_ready(0, 5000, got, cyc);
        n_total++; if (!got || cyc != 4536) $display("FAIL default_period got=%b cyc=%0d exp=4536", got, cyc); else n_pass++;
        @(negedge clk);
        n_total++; if (a_rdy !== 1'b0 || a_pwm !== 8'd128) $display("FAIL default_pulse_end rdy=%b pwm=%0d exp=0/128", a_rdy, a_pwm); else n_pass++;
    endtask

    task automatic test_single_voice();
        bit got;
        int cyc;
        apply_reset();
        smp[0] = 8'd255;
        von = 8'h01;
        load_target(3'd0, 8'd128);
        wait_ready(1, 40, got, cyc);
        wait_ready(1, 40, got, cyc);
        n_total++; if (!got || b_pwm !== 8'd159) $display("FAIL single_max got=%0d exp=159", b_pwm); else n_pass++;
        smp[0] = 8'd0;
        wait_ready(1, 40, got, cyc);
        n_total++; if (!got || b_pwm !== 8'd96) $display("FAIL single_min got=%0d exp=96", b_pwm); else n_pass++;
        repeat (4) @(negedge clk);
        n_total++; if (b_pwm !== 8'd96 || b_rdy !== 1'b0) $display("FAIL pwm_hold pwm=%0d rdy=%b exp=96/0", b_pwm, b_rdy); else n_pass++;
        smp[0] = 8'd128;
        wait_ready(1, 40, got, cyc);
        n_total++; if (!got || b_pwm !== 8'd128) $display("FAIL single_mid got=%0d exp=128", b_pwm); else n_pass++;
        smp[0] = 8'd255;
        wait_ready(1, 40, got, cyc);
        wait_state_b(2'd1, got);
        von = 8'h00;
        wait_ready(1, 40, got, cyc);
        n_total++; if (!got || b_pwm !== 8'd159) $display("FAIL snapshot_hold got=%0d exp=159", b_pwm); else n_pass++;
        wait_ready(1, 40, got, cyc);
        n_total++; if (!got || b_pwm !== 8'd128) $display("FAIL snapshot_off got=%0d exp=128", b_pwm); else n_pass++;
    endtask

    task automatic test_clip();
        bit got;
        int cyc;
        apply_reset();
        for (int i = 0; i < 8; i++) smp[i] = 8'd255;
        von = 8'hFF;
        for (int i = 0; i < 8; i++) load_target(3'(i), 8'd255);
        wait_ready(1, 40, got, cyc);
        wait_ready(1, 40, got, cyc);
        n_total++; if (!got || b_pwm !== 8'd255 || b_clip !== 1'b1) $display("FAIL clip_high pwm=%0d clip=%b exp=255/1", b_pwm, b_clip); else n_pass++;
        cc = 1'b1;
        @(negedge clk);
        cc = 1'b0;
        n_total++; if (b_clip !== 1'b0) $display("FAIL clip_clear got=%b exp=0", b_clip); else n_pass++;
        wait_state_b(2'd2, got);
        cc = 1'b1;
        @(negedge clk);
        cc = 1'b0;
        n_total++; if (!got || b_clip !== 1'b1) $display("FAIL clip_set_wins got=%b exp=1", b_clip); else n_pass++;
        wait_ready(1, 40, got, cyc);
        cc = 1'b1;
        @(negedge clk);
        cc = 1'b0;
        for (int i = 0; i < 8; i++) smp[i] = 8'd0;
        n_total++; if (b_clip !== 1'b0) $display("FAIL clip_clear2 got=%b exp=0", b_clip); else n_pass++;
        wait_ready(1, 40, got, cyc);
        n_total++; if (!got || b_pwm !== 8'd0 || b_clip !== 1'b1) $display("FAIL clip_low pwm=%0d clip=%b exp=0/1", b_pwm, b_clip); else n_pass++;
    endtask

    task automatic test_ramp();
        bit got;
        int cyc;
        int g;
        int exp_v;
        apply_reset();
        smp[2] = 8'd255;
        von = 8'h04;
        load_target(3'd2, 8'd100);
        for (int k = 1; k <= 27; k++) begin
            wait_ready(2, 40, got, cyc);
            g = 4 * (k - 1) > 100 ? 100 : 4 * (k - 1);
            exp_v = 128 + (g * 127) / 128;
            n_total++; if (!got || int'(c_pwm) != exp_v) $display("FAIL ramp_frame%0d got=%0d exp=%0d", k, c_pwm, exp_v); else n_pass++;
        end
        n_total++; if (b_pwm !== 8'd152) $display("FAIL no_ramp_gain100 got=%0d exp=152", b_pwm); else n_pass++;
    endtask

    task automatic test_vel_collision();
        bit got;
        int cyc;
        apply_reset();
        smp[3] = 8'd255;
        von = 8'h08;
        load_target(3'd3, 8'd8);
        repeat (3) wait_ready(2, 40, got, cyc);
        n_total++; if (!got || c_pwm !== 8'd135 || b_pwm !== 8'd129) $display("FAIL coll_pre c=%0d b=%0d exp=135/129", c_pwm, b_pwm); else n_pass++;
        wait_state_b(2'd1, got);
        repeat (3) @(negedge clk);
        vl = 1'b1; vi = 3'd3; vv = 8'd0;
        @(negedge clk);
        vl = 1'b0;
        wait_ready(2, 40, got, cyc);
        n_total++; if (!got || c_pwm !== 8'd135 || b_pwm !== 8'd129) $display("FAIL coll_frame c=%0d b=%0d exp=135/129", c_pwm, b_pwm); else n_pass++;
        wait_ready(2, 40, got, cyc);
        n_total++; if (!got || c_pwm !== 8'd135 || b_pwm !== 8'd128) $display("FAIL coll_next c=%0d b=%0d exp=135/128", c_pwm, b_pwm); else n_pass++;
        wait_ready(2, 40, got, cyc);
        n_total++; if (!got || c_pwm !== 8'd131) $display("FAIL coll_ramp1 c=%0d exp=131", c_pwm); else n_pass++;
        wait_ready(2, 40, got, cyc);
        n_total++; if (!got || c_pwm !== 8'd128) $display("FAIL coll_ramp2 c=%0d exp=128", c_pwm); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        bit got;
        int cyc;
        int pulses = 0;
        apply_reset();
        for (int i = 0; i < 8; i++) smp[i] = 8'd255;
        von = 8'hFF;
        for (int i = 0; i < 8; i++) load_target(3'(i), 8'd255);
        repeat (2) wait_ready(1, 40, got, cyc);
        n_total++; if (!got || b_pwm !== 8'd255 || b_clip !== 1'b1) $display("FAIL midrst_pre pwm=%0d clip=%b exp=255/1", b_pwm, b_clip); else n_pass++;
        wait_state_b(2'd1, got);
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (!got || b_pwm !== 8'd128 || b_clip !== 1'b0) $display("FAIL midrst_async pwm=%0d clip=%b exp=128/0", b_pwm, b_clip); else n_pass++;
        n_total++; if (b_state !== 2'd0 || b_busy !== 1'b0 || b_rdy !== 1'b0) $display("FAIL midrst_state state=%0d busy=%b rdy=%b exp=0/0/0", b_state, b_busy, b_rdy); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pulses += int'(b_rdy);
        end
        n_total++; if (pulses != 0) $display("FAIL midrst_no_pulse pulses=%0d exp=0", pulses); else n_pass++;
        rst_n = 1'b1;
        wait_ready(1, 60, got, cyc);
        n_total++; if (!got || cyc != 26 || b_pwm !== 8'd128) $display("FAIL midrst_restart cyc=%0d pwm=%0d exp=26/128", cyc, b_pwm); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_default_idle();
        test_single_voice();
        test_clip();
        test_ramp();
        test_vel_collision();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
